// File: rtl/uc_arbiter_mc_pkg.sv
// Shared types and constants for the unit-clause arbiter.
//   uc_arb_state_t : arbiter FSM state (IDLE/LOAD/RUN/CONFLICT)
//   lit_t / var_t  : signed literal and variable index at the default width
//   pol_t          : literal polarity (0 positive, 1 negative)
//   tbl_ent_t      : polarity table entry, bit0 = seen positive, bit1 = seen negative
package uc_pkg;

   localparam int UC_LIT_W = 10;

   typedef logic [1:0] uc_arb_state_t;
   localparam uc_arb_state_t ST_IDLE     = 2'd0;
   localparam uc_arb_state_t ST_LOAD     = 2'd1;
   localparam uc_arb_state_t ST_RUN      = 2'd2;
   localparam uc_arb_state_t ST_CONFLICT = 2'd3;

   typedef logic signed [UC_LIT_W-1:0] lit_t;
   typedef logic [UC_LIT_W-2:0]        var_t;

   typedef logic pol_t;
   localparam pol_t POL_POS = 1'b0;
   localparam pol_t POL_NEG = 1'b1;

   // 2'b11 cannot occur: the second polarity of a variable is a conflict
   // and is never written back.
   typedef logic [1:0] tbl_ent_t;
   localparam tbl_ent_t ENT_NONE  = 2'b00;
   localparam tbl_ent_t ENT_POS   = 2'b01;
   localparam tbl_ent_t ENT_NEG   = 2'b10;
   localparam tbl_ent_t ENT_NEVER = 2'b11;

   function automatic tbl_ent_t pol_to_ent(input pol_t pol);
      return (pol == POL_NEG) ? ENT_NEG : ENT_POS;
   endfunction

endpackage

// File: rtl/uc_arbiter_mc_fifo.sv
// Broadcast queue for the unit-clause arbiter.
// Storage is a register array; dout reads the head register directly so a
// word written at edge t is visible at dout right after that edge.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous empty (priority over push/pop)
//   push, din       write one word when not full
//   pop             discard head when not empty
//   dout            head word
//   empty, full     status
//   count           occupancy, 0..DEPTH
module uc_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Data storage needs no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok && !rst && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uc_arbiter_mc.sv
// Multi-engine unit-clause arbiter.
// Takes UC literals from the clause memory loader (LOAD) and then from
// NUM_ENGINE BCP engines by round-robin (RUN). A per-variable polarity table
// drops duplicates and flags conflicts; new literals are queued and broadcast,
// and the head retires once every active engine has acknowledged it.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | after reset/clear, waiting for the loader to start
// LOAD      | accepting memory literals until mem_done
// RUN       | round-robin acceptance of engine literals
// CONFLICT  | both polarities seen; everything stalled until clear/rst
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         soft restart (same effect as rst, wins over all events)
//   eng_active    engines taking part in arbitration and acknowledgement
//   mem_valid/mem_lit/mem_done/mem_ready   loader handshake
//   eng_valid/eng_lit/eng_ready            engine offers, one-hot grant
//                                          (eng_lit engine i at [i*LIT_W +: LIT_W])
//   bc_valid/bc_lit/bc_ack                 broadcast head and per-engine acks
//   conflict/conflict_var                  sticky conflict flag and variable
//   q_count                                broadcast queue occupancy
module uc_arbiter_mc
   import uc_pkg::*;
#(
   parameter int NUM_ENGINE = 4,
   parameter int LIT_W      = 10,
   parameter int Q_DEPTH    = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic [NUM_ENGINE-1:0]         eng_active,
   input  logic                          mem_valid,
   input  logic signed [LIT_W-1:0]       mem_lit,
   input  logic                          mem_done,
   output logic                          mem_ready,
   input  logic [NUM_ENGINE-1:0]         eng_valid,
   input  logic [NUM_ENGINE*LIT_W-1:0]   eng_lit,
   output logic [NUM_ENGINE-1:0]         eng_ready,
   output logic                          bc_valid,
   output logic signed [LIT_W-1:0]       bc_lit,
   input  logic [NUM_ENGINE-1:0]         bc_ack,
   output logic                          conflict,
   output logic [LIT_W-2:0]              conflict_var,
   output logic [$clog2(Q_DEPTH):0]      q_count
);

   localparam int NUM_VARS = 2 ** (LIT_W - 1);
   localparam int PTR_W    = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
   localparam logic [LIT_W-1:0] LIT_MIN = {1'b1, {(LIT_W-1){1'b0}}};

   uc_arb_state_t state_q, state_d;

   tbl_ent_t tbl_q [NUM_VARS];

   logic [PTR_W-1:0]      rr_ptr_q;
   logic [NUM_ENGINE-1:0] ack_mask_q;
   logic                  conflict_q;
   logic [LIT_W-2:0]      conflict_var_q;

   logic [LIT_W-1:0]      fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [$clog2(Q_DEPTH):0] fifo_count;

   // ---------------- round-robin grant ----------------
   logic [NUM_ENGINE-1:0] eng_req;
   logic [NUM_ENGINE-1:0] gnt;
   logic [PTR_W-1:0]      gnt_idx;
   logic [PTR_W-1:0]      rr_next;
   logic                  gnt_any;
   logic [LIT_W-1:0]      eng_sel;

   assign eng_req = eng_valid & eng_active;

   always_comb begin
      int               idx;
      logic [PTR_W-1:0] idx_p;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      idx_p   = '0;
      if (state_q == ST_RUN && !fifo_full) begin
         for (int k = 0; k < NUM_ENGINE; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_ENGINE) idx = idx - NUM_ENGINE;
            idx_p = PTR_W'(idx);
            if (!gnt_any && eng_req[idx_p]) begin
               gnt_any    = 1'b1;
               gnt[idx_p] = 1'b1;
               gnt_idx    = idx_p;
            end
         end
      end
   end

   assign rr_next = (gnt_idx == PTR_W'(NUM_ENGINE - 1)) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      eng_sel = '0;
      for (int k = 0; k < NUM_ENGINE; k++) begin
         if (gnt[k]) eng_sel = eng_lit[k*LIT_W +: LIT_W];
      end
   end

   // ---------------- literal check ----------------
   logic                    mem_fire;
   logic                    acc_valid;
   logic signed [LIT_W-1:0] acc_lit;
   logic                    acc_neg;
   logic [LIT_W-2:0]        acc_var;
   tbl_ent_t                acc_ent;
   tbl_ent_t                pol_ent;
   logic                    lit_ok;
   logic                    hit_same;
   logic                    hit_other;
   logic                    conflict_det;
   logic                    do_push;

   assign mem_ready = (state_q == ST_LOAD) && !fifo_full;
   assign mem_fire  = mem_valid && mem_ready;
   assign acc_valid = mem_fire || gnt_any;
   assign acc_lit   = mem_fire ? mem_lit : eng_sel;
   assign acc_neg   = acc_lit[LIT_W-1];
   // |L| always fits in LIT_W-1 bits once the most negative code is excluded,
   // so negating the low bits alone gives the variable index.
   assign acc_var   = acc_neg ? (~acc_lit[LIT_W-2:0] + 1'b1) : acc_lit[LIT_W-2:0];
   assign acc_ent   = tbl_q[acc_var];
   assign pol_ent   = pol_to_ent(acc_neg);
   assign lit_ok    = acc_valid && (acc_lit != '0) && (acc_lit != LIT_MIN);
   assign hit_same  = (acc_ent & pol_ent) != ENT_NONE;
   assign hit_other = (acc_ent & ~pol_ent) != ENT_NONE;

   assign conflict_det = lit_ok && !hit_same && hit_other && !clear;
   assign do_push      = lit_ok && !hit_same && !hit_other && !clear;

   // ---------------- broadcast / ack tracking ----------------
   logic                  bc_valid_i;
   logic [NUM_ENGINE-1:0] ack_cover;
   logic                  do_pop;

   assign bc_valid_i = (state_q != ST_CONFLICT) && !fifo_empty;
   assign ack_cover  = (ack_mask_q | bc_ack) & eng_active;
   // With no active engine the cover test is trivially true: head pops at once.
   assign do_pop     = bc_valid_i && (ack_cover == eng_active) && !conflict_det && !clear;

   uc_fifo #(
      .WIDTH (LIT_W),
      .DEPTH (Q_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clear || conflict_det),
      .push  (do_push),
      .din   (acc_lit),
      .pop   (do_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mem_valid || mem_done) state_d = ST_LOAD;
         // Leave LOAD only once a literal offered alongside mem_done is taken.
         ST_LOAD: if (mem_done && !(mem_valid && !mem_ready)) state_d = ST_RUN;
         default: state_d = state_q;
      endcase
      if (conflict_det) state_d = ST_CONFLICT;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         ack_mask_q     <= '0;
         conflict_q     <= 1'b0;
         conflict_var_q <= '0;
      end else begin
         state_q <= state_d;
         if (gnt_any) rr_ptr_q <= rr_next;
         if (!bc_valid_i || do_pop || conflict_det) ack_mask_q <= '0;
         else                                       ack_mask_q <= ack_cover;
         if (conflict_det) begin
            conflict_q     <= 1'b1;
            conflict_var_q <= acc_var;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < NUM_VARS; i++) tbl_q[i] <= ENT_NONE;
      end else if (do_push) begin
         tbl_q[acc_var] <= acc_ent | pol_ent;
      end
   end

   assign eng_ready    = gnt;
   assign bc_valid     = bc_valid_i;
   assign bc_lit       = bc_valid_i ? fifo_dout : '0;
   assign conflict     = conflict_q;
   assign conflict_var = conflict_var_q;
   assign q_count      = fifo_count;

endmodule

// File: tb/tb_uc_arbiter_mc.sv
module tb_uc_arbiter_mc;

   localparam int NE = 4;
   localparam int LW = 10;
   localparam int QD = 64;
   localparam int CW = $clog2(QD) + 1;
   localparam int OW = 1 + NE + 1 + LW + 1 + (LW - 1) + CW;

   logic                 clk = 1'b0;
   logic                 rst, clear;
   logic [NE-1:0]        eng_active;
   logic                 mem_valid, mem_done, mem_ready;
   logic signed [LW-1:0] mem_lit;
   logic [NE-1:0]        eng_valid, eng_ready, bc_ack;
   logic signed [LW-1:0] elit [NE];
   logic [NE*LW-1:0]     eng_lit;
   logic                 bc_valid, conflict;
   logic signed [LW-1:0] bc_lit;
   logic [LW-2:0]        conflict_var;
   logic [CW-1:0]        q_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always_comb begin
      eng_lit = '0;
      for (int k = 0; k < NE; k++) eng_lit[k*LW +: LW] = elit[k];
   end

   uc_arbiter_mc #(.NUM_ENGINE(NE), .LIT_W(LW), .Q_DEPTH(QD)) dut (
      .clk(clk), .rst(rst), .clear(clear), .eng_active(eng_active),
      .mem_valid(mem_valid), .mem_lit(mem_lit), .mem_done(mem_done), .mem_ready(mem_ready),
      .eng_valid(eng_valid), .eng_lit(eng_lit), .eng_ready(eng_ready),
      .bc_valid(bc_valid), .bc_lit(bc_lit), .bc_ack(bc_ack),
      .conflict(conflict), .conflict_var(conflict_var), .q_count(q_count)
   );

   logic [OW-1:0] obs_vec, exp_vec;
   assign obs_vec = {mem_ready, eng_ready, bc_valid, bc_lit, conflict, conflict_var, q_count};

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_LOAD, M_RUN, M_CONF} mstate_e;
   mstate_e m_st = M_IDLE;
   bit      m_pos[int];
   bit      m_neg[int];
   int      m_q[$];
   logic [NE-1:0] m_acked = '0;
   int      m_rr = 0;
   bit      m_conf = 0;
   int      m_cvar = 0;

   bit            e_mem_ready, e_bc_valid;
   logic [NE-1:0] e_eng_ready;
   int            e_gnt, e_bc_lit;

   task automatic model_expect();
      bit full;
      int i;
      full = (m_q.size() == QD);
      e_mem_ready = (m_st == M_LOAD) && !full;
      e_gnt = -1;
      e_eng_ready = '0;
      if (m_st == M_RUN && !full) begin
         for (int k = 0; k < NE; k++) begin
            i = (m_rr + k) % NE;
            if (e_gnt < 0 && (((eng_valid & eng_active) >> i) & NE'(1)) != '0) e_gnt = i;
         end
      end
      if (e_gnt >= 0) e_eng_ready = NE'(1) << e_gnt;
      e_bc_valid = (m_st != M_CONF) && (m_q.size() > 0);
      e_bc_lit = e_bc_valid ? m_q[0] : 0;
      exp_vec = {e_mem_ready, e_eng_ready, e_bc_valid, LW'(e_bc_lit), m_conf,
                 (LW-1)'(m_cvar), CW'(m_q.size())};
   endtask

   task automatic model_commit();
      bit have, pop, neg, is_new, is_conf;
      int lit, v;
      logic [NE*LW-1:0] tmp;
      if (rst || clear) begin
         m_st = M_IDLE; m_pos.delete(); m_neg.delete(); m_q.delete();
         m_acked = '0; m_rr = 0; m_conf = 0; m_cvar = 0;
         return;
      end
      have = 0; lit = 0; is_new = 0; is_conf = 0; v = 0;
      if (mem_valid && e_mem_ready) begin
         have = 1; lit = int'(mem_lit);
      end else if (e_gnt >= 0) begin
         have = 1;
         tmp = eng_lit >> (e_gnt * LW);
         lit = int'($signed(tmp[LW-1:0]));
         m_rr = (e_gnt + 1) % NE;
      end
      pop = e_bc_valid && (((m_acked | bc_ack) & eng_active) == eng_active);
      if (have && lit != 0 && lit != -(1 << (LW - 1))) begin
         neg = (lit < 0);
         v = neg ? -lit : lit;
         if (neg ? m_neg.exists(v) : m_pos.exists(v)) ;
         else if (neg ? m_pos.exists(v) : m_neg.exists(v)) is_conf = 1;
         else begin
            is_new = 1;
            if (neg) m_neg[v] = 1; else m_pos[v] = 1;
         end
      end
      if (is_conf) begin
         m_st = M_CONF; m_conf = 1; m_cvar = v; m_q.delete(); m_acked = '0;
         return;
      end
      if (pop) void'(m_q.pop_front());
      if (is_new) m_q.push_back(lit);
      m_acked = (pop || !e_bc_valid) ? '0 : ((m_acked | bc_ack) & eng_active);
      if (m_st == M_IDLE && (mem_valid || mem_done)) m_st = M_LOAD;
      else if (m_st == M_LOAD && mem_done && !(mem_valid && !e_mem_ready)) m_st = M_RUN;
   endtask

   // ---------------- cycle plumbing (inputs change just after negedge) ----------------
   task automatic settle();
      #1;
      model_expect();
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic zero_inputs();
      clear = 0; mem_valid = 0; mem_done = 0; mem_lit = '0;
      eng_valid = '0; bc_ack = '0; eng_active = '1;
      for (int k = 0; k < NE; k++) elit[k] = '0;
   endtask

   task automatic do_reset();
      zero_inputs();
      rst = 1;
      advance();
      rst = 0;
   endtask

   task automatic enter_run();
      mem_done = 1;
      advance();
      advance();
      mem_done = 0;
   endtask

   task automatic load_list(input int lits[$], input string nm);
      int idx = 0;
      int guard = 0;
      while (idx < lits.size() && guard < 40) begin
         mem_valid = 1;
         mem_lit = LW'(lits[idx]);
         mem_done = (idx == lits.size() - 1);
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL %s_load cycle %0d: got %h expected %h", nm, guard, obs_vec, exp_vec);
         end
         if (mem_ready) idx++;
         advance();
         guard++;
      end
      mem_valid = 0; mem_done = 0; mem_lit = '0;
      checks++;
      if (idx != lits.size()) begin
         errors++;
         $display("FAIL %s_load_timeout: accepted %0d expected %0d", nm, idx, lits.size());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      zero_inputs();
      rst = 1; mem_valid = 1; mem_done = 1; eng_valid = '1; bc_ack = '1;
      advance();
      advance();
      zero_inputs();
      settle();
      checks++;
      if (obs_vec !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", obs_vec);
      end
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL reset_model: got %h expected %h", obs_vec, exp_vec);
      end
      rst = 0;
   endtask

   task automatic test_load();
      int lits[$] = '{3, -5, 7};
      int got[$];
      int got_cyc[$];
      int idx = 0;
      do_reset();
      bc_ack = '1;
      for (int c = 0; c < 10; c++) begin
         mem_valid = (idx < 3);
         mem_lit = (idx < 3) ? LW'(lits[idx]) : '0;
         mem_done = (idx == 2);
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL load cycle %0d: got %h expected %h", c, obs_vec, exp_vec);
         end
         if (bc_valid) begin
            got.push_back(int'(bc_lit));
            got_cyc.push_back(c);
         end
         if (mem_valid && mem_ready) idx++;
         advance();
      end
      zero_inputs();
      bc_ack = '1;
      checks++;
      if (got.size() != 3 || got[0] != 3 || got[1] != -5 || got[2] != 7) begin
         errors++;
         $display("FAIL load_bc_sequence: got %p expected '{3, -5, 7}", got);
      end
      checks++;
      if (got_cyc.size() != 3 || got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
         errors++;
         $display("FAIL load_bc_consecutive: cycles %p expected consecutive", got_cyc);
      end
      eng_valid = 4'b0001; elit[0] = LW'(9);
      settle();
      checks++;
      if (eng_ready !== 4'b0001) begin
         errors++;
         $display("FAIL load_run_state: eng_ready %b expected 0001", eng_ready);
      end
      advance();
      eng_valid = '0;
   endtask

   task automatic test_dedup();
      do_reset();
      bc_ack = '1;
      load_list('{3}, "dedup");
      eng_valid = 4'b0010; elit[1] = LW'(3);
      settle();
      checks++;
      if (eng_ready !== 4'b0010) begin
         errors++;
         $display("FAIL dedup_grant: eng_ready %b expected 0010", eng_ready);
      end
      advance();
      eng_valid = '0;
      settle();
      checks++;
      if (q_count !== '0 || conflict !== 1'b0) begin
         errors++;
         $display("FAIL dedup_nopush: q_count %0d conflict %b expected 0 0", q_count, conflict);
      end
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL dedup_model: got %h expected %h", obs_vec, exp_vec);
      end
      advance();
   endtask

   task automatic test_conflict();
      do_reset();
      bc_ack = '1;
      load_list('{3}, "conflict");
      eng_valid = 4'b0100; elit[2] = -LW'(3);
      settle();
      checks++;
      if (eng_ready !== 4'b0100) begin
         errors++;
         $display("FAIL conflict_grant: eng_ready %b expected 0100", eng_ready);
      end
      advance();
      eng_valid = '0;
      settle();
      checks++;
      if (conflict !== 1'b1 || conflict_var !== 9'd3 || bc_valid !== 1'b0) begin
         errors++;
         $display("FAIL conflict_flag: conflict %b var %0d bc_valid %b expected 1 3 0",
                  conflict, conflict_var, bc_valid);
      end
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL conflict_model: got %h expected %h", obs_vec, exp_vec);
      end
      clear = 1;
      advance();
      clear = 0;
      settle();
      checks++;
      if (obs_vec !== '0) begin
         errors++;
         $display("FAIL conflict_clear: got %h expected 0", obs_vec);
      end
      mem_valid = 1; mem_lit = LW'(4);
      settle();
      checks++;
      if (mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_idle: mem_ready %b expected 0", mem_ready);
      end
      advance();
      settle();
      checks++;
      if (mem_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_to_load: mem_ready %b expected 1", mem_ready);
      end
      mem_valid = 0;
      advance();
   endtask

   task automatic test_round_robin();
      int w;
      int next_lit = 20;
      do_reset();
      bc_ack = '1;
      enter_run();
      eng_valid = '1;
      for (int k = 0; k < NE; k++) elit[k] = LW'(k + 1);
      for (int c = 0; c < NE; c++) begin
         settle();
         w = -1;
         for (int k = 0; k < NE; k++) if (eng_ready[k]) w = k;
         checks++;
         if (w !== c) begin
            errors++;
            $display("FAIL rr_order step %0d: granted %0d expected %0d", c, w, c);
         end
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL rr_model step %0d: got %h expected %h", c, obs_vec, exp_vec);
         end
         advance();
         for (int k = 0; k < NE; k++) if (k == w) eng_valid[k] = 1'b0;
      end
      for (int c = 0; c < 40; c++) begin
         eng_valid = NE'($urandom_range(0, 15));
         for (int k = 0; k < NE; k++) begin
            elit[k] = LW'(next_lit);
            next_lit++;
         end
         bc_ack = ($urandom_range(0, 3) == 0) ? NE'($urandom_range(0, 15)) : '1;
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL rr_random cycle %0d: got %h expected %h", c, obs_vec, exp_vec);
         end
         advance();
      end
      eng_valid = '0;
   endtask

   task automatic test_ack_gating();
      do_reset();
      eng_active = 4'b1011;
      load_list('{5}, "ack");
      bc_ack = 4'b0011;
      for (int c = 0; c < 2; c++) begin
         settle();
         checks++;
         if (bc_valid !== 1'b1 || bc_lit !== 10'sd5) begin
            errors++;
            $display("FAIL ack_hold01 cycle %0d: bc_valid %b bc_lit %0d expected 1 5", c, bc_valid, bc_lit);
         end
         advance();
      end
      bc_ack = 4'b0100;
      settle();
      advance();
      settle();
      checks++;
      if (bc_valid !== 1'b1 || q_count !== 7'd1) begin
         errors++;
         $display("FAIL ack_inactive_ignored: bc_valid %b q_count %0d expected 1 1", bc_valid, q_count);
      end
      bc_ack = 4'b1000;
      settle();
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL ack_model: got %h expected %h", obs_vec, exp_vec);
      end
      advance();
      bc_ack = '0;
      settle();
      checks++;
      if (bc_valid !== 1'b0 || q_count !== '0) begin
         errors++;
         $display("FAIL ack_pop: bc_valid %b q_count %0d expected 0 0", bc_valid, q_count);
      end
      advance();
   endtask

   task automatic test_full_reset();
      int next_lit = 1;
      int w;
      do_reset();
      enter_run();
      eng_valid = '1;
      for (int k = 0; k < NE; k++) begin
         elit[k] = LW'(next_lit);
         next_lit++;
      end
      for (int c = 0; c < QD + 6; c++) begin
         settle();
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL full_fill cycle %0d: got %h expected %h", c, obs_vec, exp_vec);
         end
         w = -1;
         for (int k = 0; k < NE; k++) if (eng_ready[k]) w = k;
         advance();
         for (int k = 0; k < NE; k++) begin
            if (k == w) begin
               elit[k] = LW'(next_lit);
               next_lit++;
            end
         end
      end
      settle();
      checks++;
      if (q_count !== CW'(QD) || eng_ready !== '0) begin
         errors++;
         $display("FAIL full_stall: q_count %0d eng_ready %b expected %0d 0000", q_count, eng_ready, QD);
      end
      rst = 1;
      advance();
      rst = 0;
      eng_valid = '0;
      settle();
      checks++;
      if (q_count !== '0 || conflict !== 1'b0) begin
         errors++;
         $display("FAIL full_rst: q_count %0d conflict %b expected 0 0", q_count, conflict);
      end
      enter_run();
      eng_valid = 4'b0001; elit[0] = LW'(1);
      settle();
      checks++;
      if (eng_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rst_regrant: eng_ready %b expected 0001", eng_ready);
      end
      advance();
      eng_valid = '0;
      settle();
      checks++;
      if (q_count !== 7'd1 || bc_lit !== 10'sd1) begin
         errors++;
         $display("FAIL rst_table_clear: q_count %0d bc_lit %0d expected 1 1", q_count, bc_lit);
      end
      advance();
   endtask

   function automatic logic [LW-1:0] rand_lit();
      if ($urandom_range(0, 40) == 0) return {1'b1, {(LW-1){1'b0}}};
      return LW'(int'($urandom_range(0, 24)) - 12);
   endfunction

   task automatic test_random();
      for (int b = 0; b < 6; b++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            clear      = ($urandom_range(0, 59) == 0);
            eng_active = ($urandom_range(0, 3) == 0) ? NE'($urandom_range(0, 15)) : '1;
            mem_valid  = ($urandom_range(0, 2) != 0);
            mem_lit    = rand_lit();
            mem_done   = ($urandom_range(0, 19) == 0);
            eng_valid  = NE'($urandom_range(0, 15));
            for (int k = 0; k < NE; k++) elit[k] = rand_lit();
            bc_ack     = ($urandom_range(0, 1) == 0) ? NE'($urandom_range(0, 15)) : '1;
            settle();
            checks++;
            if (obs_vec !== exp_vec) begin
               errors++;
               $display("FAIL random burst %0d cycle %0d: got %h expected %h", b, c, obs_vec, exp_vec);
            end
            advance();
         end
      end
      zero_inputs();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      zero_inputs();
      rst = 1;
      @(negedge clk);
      test_reset();
      test_load();
      test_dedup();
      test_conflict();
      test_round_robin();
      test_ack_gating();
      test_full_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
